// File: rtl/npu_result_pool.sv
// Max-pools the PE result stream over POOL_SIZE valid inputs and buffers results in a FWFT FIFO.
// Optional: define RESULT_POOL_RELU_EN to clamp negative pooled values to zero before buffering.
module npu_result_pool #(
    parameter int DATA_WIDTH = 8,
    parameter int POOL_SIZE  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_result,
    input  logic                          i_clear,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POOL_SIZE) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_CNT = PW'(POOL_SIZE - 1);

    typedef enum logic {IDLE, ACCUM} pool_state_t;

    pool_state_t           state, state_nxt;
    logic [PW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] max_reg, max_nxt;
    logic [DATA_WIDTH-1:0] cand, push_val;
    logic                  push;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  empty, full, pop, push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            max_reg <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            max_reg <= max_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        max_nxt   = max_reg;
        cand      = max_reg;
        push      = 1'b0;
        if (i_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (i_valid) begin
            case (state)
                IDLE: begin
                    cand    = i_result;
                    max_nxt = i_result;
                    if (POOL_SIZE == 1) begin
                        push = 1'b1;
                    end else begin
                        cnt_nxt   = PW'(1);
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    cand = ($signed(i_result) > $signed(max_reg)) ? i_result : max_reg;
                    if (cnt == LAST_CNT) begin
                        push      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        max_nxt = cand;
                        cnt_nxt = cnt + PW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef RESULT_POOL_RELU_EN
    assign push_val = cand[DATA_WIDTH-1] ? '0 : cand;
`else
    assign push_val = cand;
`endif

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = !empty && i_ready;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (i_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_val;
    end

    assign o_valid    = !empty;
    assign o_data     = empty ? '0 : mem[rd_ptr];
    assign o_count    = count;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_npu_result_pool.sv
// Randomized self-checking bench for npu_result_pool against a queue-based pooling/FIFO model.
module tb_npu_result_pool;

    localparam int DW = 8;
    localparam int PS = 2;
    localparam int FD = 8;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_clear, i_ready;
    logic [DW-1:0] i_result;
    logic          o_valid, o_overflow;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;

    int n_cmp = 0;
    int n_bad = 0;

    int win[$];
    int fifo[$];
    bit ovf;

    npu_result_pool #(.DATA_WIDTH(DW), .POOL_SIZE(PS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_result(i_result), .i_clear(i_clear),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_count(o_count),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic exp_valid();
        return fifo.size() != 0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        logic [DW-1:0] v;
        v = '0;
        if (fifo.size() != 0) v = DW'(fifo[0]);
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_count();
        return CW'(fifo.size());
    endfunction

    function automatic void model_reset();
        win.delete();
        fifo.delete();
        ovf = 1'b0;
    endfunction

    // Drive one cycle of inputs, advance the model by one clock, return #1 after the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
        bit pop;
        bit push;
        int pv;
        i_valid  = v;
        i_result = d;
        i_ready  = r;
        i_clear  = c;
        push = 1'b0;
        pv   = 0;
        if (c) begin
            model_reset();
        end else begin
            pop = (fifo.size() != 0) && r;
            if (v) begin
                win.push_back(int'($signed(d)));
                if (win.size() == PS) begin
                    pv = win[0];
                    foreach (win[k]) if (win[k] > pv) pv = win[k];
`ifdef RESULT_POOL_RELU_EN
                    if (pv < 0) pv = 0;
`endif
                    push = 1'b1;
                    win.delete();
                end
            end
            if (pop) void'(fifo.pop_front());
            if (push) begin
                if (fifo.size() < FD) fifo.push_back(pv);
                else ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_cmp++; if (o_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=00", o_data); end
        n_cmp++; if (o_count !== '0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
    endtask

    task automatic test_basic();
        step(1'b1, 8'd3, 1'b1, 1'b0);
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_mid_valid got=%b exp=0", o_valid); end
        step(1'b1, 8'd7, 1'b1, 1'b0);
        n_cmp++; if (o_valid !== 1'b1 || o_data !== 8'd7) begin
            n_bad++; $display("FAIL basic_out got=%b/%h exp=1/07", o_valid, o_data);
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);
        n_cmp++; if (o_valid !== exp_valid() || o_count !== exp_count()) begin
            n_bad++; $display("FAIL basic_after got=%b/%0d exp=%b/%0d", o_valid, o_count, exp_valid(), exp_count());
        end
    endtask

    task automatic test_signed();
        step(1'b1, 8'hFB, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b0);
        n_cmp++; if (o_data !== exp_data() || o_valid !== 1'b1) begin
            n_bad++; $display("FAIL signed_max got=%h exp=%h", o_data, exp_data());
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);
        n_cmp++; if (o_count !== exp_count()) begin n_bad++; $display("FAIL signed_drain got=%0d exp=%0d", o_count, exp_count()); end
    endtask

    task automatic test_backpressure();
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * (FD + 1); i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        n_cmp++; if (o_count !== CW'(FD) || o_count !== exp_count()) begin
            n_bad++; $display("FAIL bp_count got=%0d exp=%0d", o_count, FD);
        end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL bp_ovf got=%b exp=1", o_overflow); end
        for (int i = 0; i < FD; i++) begin
            n_cmp++; if (o_valid !== 1'b1 || o_data !== exp_data()) begin
                n_bad++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, o_valid, o_data, exp_data());
            end
            step(1'b0, 8'd0, 1'b1, 1'b0);
        end
        n_cmp++; if (o_valid !== 1'b0 || o_count !== '0 || o_overflow !== ovf) begin
            n_bad++; $display("FAIL bp_empty got=%b/%0d/%b exp=0/0/%b", o_valid, o_count, o_overflow, ovf);
        end
    endtask

    task automatic test_push_pop_full();
        step(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * FD; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b1, 1'b0);
        n_cmp++; if (o_count !== CW'(FD) || o_overflow !== 1'b0) begin
            n_bad++; $display("FAIL ppfull got=%0d/%b exp=%0d/0", o_count, o_overflow, FD);
        end
        for (int i = 0; i < FD; i++) begin
            n_cmp++; if (o_data !== exp_data()) begin
                n_bad++; $display("FAIL ppfull_drain%0d got=%h exp=%h", i, o_data, exp_data());
            end
            step(1'b0, 8'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 2 * (FD + 1); i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'd10, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        n_cmp++; if (o_overflow !== 1'b0 || o_count !== '0 || o_valid !== 1'b0) begin
            n_bad++; $display("FAIL clear_state got=%b/%0d/%b exp=0/0/0", o_overflow, o_count, o_valid);
        end
        step(1'b1, 8'd1, 1'b0, 1'b0);
        step(1'b1, 8'd2, 1'b0, 1'b0);
        n_cmp++; if (o_data !== 8'd2 || o_count !== CW'(1) || o_data !== exp_data()) begin
            n_bad++; $display("FAIL clear_window got=%h/%0d exp=02/1", o_data, o_count);
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        n_cmp++; if (o_count !== CW'(3)) begin n_bad++; $display("FAIL areset_pre got=%0d exp=3", o_count); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_count !== '0 || o_data !== '0) begin
            n_bad++; $display("FAIL areset_now got=%b/%0d/%h exp=0/0/00", o_valid, o_count, o_data);
        end
        model_reset();
        #1 rst = 1'b0;
        step(1'b1, 8'd4, 1'b0, 1'b0);
        step(1'b1, 8'd6, 1'b0, 1'b0);
        n_cmp++; if (o_data !== 8'd6 || o_count !== CW'(1)) begin
            n_bad++; $display("FAIL areset_after got=%h/%0d exp=06/1", o_data, o_count);
        end
        step(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 63) == 0));
            n_cmp++; if (o_valid !== exp_valid() || o_data !== exp_data() ||
                         o_count !== exp_count() || o_overflow !== ovf) begin
                n_bad++;
                $display("FAIL random%0d got=%b/%h/%0d/%b exp=%b/%h/%0d/%b", i, o_valid, o_data,
                         o_count, o_overflow, exp_valid(), exp_data(), exp_count(), ovf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b0; i_result = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_push_pop_full();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/npu_result_pool.md
Name: npu_result_pool

Overview:
Downstream stage of the NPU processing element. Consumes the PE's 8-bit result/valid stream, performs 1-D max-pooling over POOL_SIZE consecutive results, and buffers pooled values in a small FIFO. Results are presented to the writeback/host side via a valid/ready handshake. The PE has no backpressure, so FIFO overrun is flagged rather than stalled.

Parameters:
DATA_WIDTH, 8, width of PE result and pooled output (signed two's complement)
POOL_SIZE, 2, number of consecutive valid inputs reduced by max (legal 1..16)
FIFO_DEPTH, 8, pooled-result buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_valid  input  1  PE result valid (single-cycle strobes, may be back-to-back)
i_result  input  DATA_WIDTH  PE result, signed
i_clear  input  1  synchronous flush: pool state, FIFO and overflow flag
o_valid  output  1  FIFO head valid
o_data  output  DATA_WIDTH  FIFO head (pooled value)
i_ready  input  1  downstream accepts o_data when o_valid && i_ready
o_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_overflow  output  1  sticky: a pooled value was dropped because FIFO full

Behaviour:
- Reset (rst high, async): pool counter=0, running max cleared, FIFO empty; o_valid=0, o_data=0, o_count=0, o_overflow=0.
- Pool FSM: IDLE (cnt=0) / ACCUM (0<cnt<POOL_SIZE).
  - IDLE + i_valid: max_reg<=i_result, cnt<=1; if POOL_SIZE==1, push immediately, stay IDLE.
  - ACCUM + i_valid: cand = signed max(max_reg, i_result); if cnt==POOL_SIZE-1 push cand, cnt<=0 -> IDLE; else max_reg<=cand, cnt<=cnt+1.
  - No i_valid: hold state indefinitely (no timeout).
- Comparison is signed; ties keep either (equal value).
- Push happens on the same edge that samples the final input of a window; o_valid rises the following cycle when FIFO was empty (latency 1 cycle from final i_valid edge).
- FIFO: first-word-fall-through; o_valid = !empty; o_data = head entry, 0 when empty; o_data stable while o_valid && !i_ready.
- Pop on o_valid && i_ready at the clock edge.
- Push while full with no pop in same cycle: value dropped, o_overflow<=1 (sticky), pool FSM still returns to IDLE.
- Push while full with pop in same cycle: both occur, no overflow, o_count unchanged.
- Push and pop when count==1: head replaced by new value, o_valid stays 1.
- Pointers wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.
- i_clear (synchronous, highest priority over i_valid/pop in that cycle): cnt<=0, FIFO emptied, o_overflow<=0; input sampled that cycle is discarded.
- Async rst asserted mid-window or with FIFO non-empty: all state lost immediately, outputs to reset values without waiting for clk.

Optional Feature:
RESULT_POOL_RELU_EN: when defined, the pooled value is passed through ReLU before push (negative -> 0, else unchanged). Overflow/handshake unaffected. When undefined, the signed max is pushed unchanged.

Test Plan:
- Reset then POOL_SIZE=2, inputs 3,7 back-to-back, i_ready=1 -> o_valid one cycle after second input, o_data=7, then o_valid=0.
- Signed compare: inputs -5 (0xFB), -2 (0xFE) -> o_data=0xFE; with RESULT_POOL_RELU_EN -> o_data=0x00.
- Backpressure: i_ready=0, 9 windows (18 inputs) with FIFO_DEPTH=8 -> o_count=8, o_overflow=1 after 9th window; raise i_ready -> first 8 pooled values drain in order, 9th absent.
- Simultaneous push/pop at full: FIFO full, i_ready=1 on cycle a window completes -> o_count stays 8, o_overflow stays 0.
- Partial window + i_clear: input 10, then i_clear, then inputs 1,2 -> single output o_data=2 (10 discarded); o_overflow cleared.
- Async rst asserted between clock edges with 3 entries buffered and cnt=1 -> o_valid, o_count, o_data go 0 before next edge; subsequent window 4,6 yields 6.
